// File: rtl/glb_stream_rx.sv
// glb_stream_rx: GLB stream receiver that buffers one flush-armed transfer of TX_SIZE words in a small FIFO toward the core
// Ports: clk; rst_n (asynchronous, active-high); flush (arm/restart strobe)
//        in_data/in_valid/in_ready (upstream side), out_data/out_valid/out_ready (core side)
//        tx_count (words delivered in this transfer), done (transfer fully delivered)
module glb_stream_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TX_SIZE    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           tx_count,
    output logic                  done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] TX_LAST = 16'(TX_SIZE);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} state_t;
    state_t state, state_nxt;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] occ;
    logic [15:0] rx_count;
    logic flush_q, rise, fall, clear, push, pop;
    assign rise = flush & ~flush_q;
    assign fall = ~flush & flush_q;
    // a restart during or after a transfer wins over any same-cycle handshake
    assign clear = rise & (state == RUN || state == DONE);
    assign in_ready = state == RUN && occ < DEPTH && rx_count < TX_LAST;
    assign out_valid = occ != '0;
    assign out_data = out_valid ? mem[rd_ptr] : '0;
    assign push = in_valid & in_ready & ~clear;
    assign pop = out_valid & out_ready & ~clear;
    assign done = state == DONE;
    // tx_count can only equal TX_SIZE once every accepted word has left, so the empty test is a guard
    always_comb begin
        state_nxt = state;
        state_nxt = (rise && state != ARMED) ? ARMED :
                    (fall && state == ARMED) ? RUN :
                    (state == RUN && tx_count == TX_LAST && occ == '0) ? DONE : state;
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= IDLE;
            flush_q  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            rx_count <= '0;
            tx_count <= '0;
        end else begin
            state   <= state_nxt;
            flush_q <= flush;
            if (clear) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                occ      <= '0;
                rx_count <= '0;
                tx_count <= '0;
            end else begin
                // power-of-two depth lets the pointers wrap by plain overflow
                if (push) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    rx_count <= rx_count + 16'd1;
                end
                if (pop) begin
                    rd_ptr   <= rd_ptr + 1'b1;
                    tx_count <= tx_count + 16'd1;
                end
                occ <= occ + (AW + 1)'(push) - (AW + 1)'(pop);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_glb_stream_rx.sv
// tb_glb_stream_rx: vector table, directed transfer sequences and a randomized queue-model run for glb_stream_rx
module tb_glb_stream_rx;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic f8, iv8, or8, ir8, ov8, dn8;
    logic [15:0] id8, od8, txd8;
    logic f2, iv2, or2, ir2, ov2, dn2;
    logic [15:0] id2, od2, txd2;

    glb_stream_rx #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .TX_SIZE(8)) u_dut8 (
        .clk(clk), .rst_n(rst), .flush(f8), .in_data(id8), .in_valid(iv8), .in_ready(ir8),
        .out_data(od8), .out_valid(ov8), .out_ready(or8), .tx_count(txd8), .done(dn8)
    );
    glb_stream_rx #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .TX_SIZE(200)) u_dut200 (
        .clk(clk), .rst_n(rst), .flush(f2), .in_data(id2), .in_valid(iv2), .in_ready(ir2),
        .out_data(od2), .out_valid(ov2), .out_ready(or2), .tx_count(txd2), .done(dn2)
    );

    int total = 0;
    int passed = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // transfer model for the TX_SIZE=8 instance: phase 0 idle, 1 armed, 2 run, 3 done
    logic [15:0] q8[$];
    int rx8, tx8, ph8, pushes8;
    bit dm8, fq8;

    task automatic model8_clear();
        q8.delete();
        rx8 = 0; tx8 = 0; ph8 = 0; dm8 = 0; fq8 = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        f8 = 0; iv8 = 0; or8 = 0; id8 = '0;
        f2 = 0; iv2 = 0; or2 = 0; id2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model8_clear();
    endtask

    task automatic cyc8();
        bit rise, fall, clr, take, give, exp_ir;
        @(negedge clk);
        exp_ir = ph8 == 2 && q8.size() < 4 && rx8 < 8;
        check("in_ready8", ir8, exp_ir);
        check("out_valid8", ov8, q8.size() != 0);
        check("out_data8", od8, q8.size() != 0 ? q8[0] : 16'h0);
        check("tx_count8", txd8, tx8);
        check("done8", dn8, dm8);
        if (iv8 && ir8) pushes8++;
        rise = f8 && !fq8;
        fall = !f8 && fq8;
        clr = rise && (ph8 == 2 || ph8 == 3);
        take = iv8 && exp_ir && !clr;
        give = q8.size() != 0 && or8 && !clr;
        @(posedge clk);
        #1;
        if (clr) begin
            q8.delete();
            rx8 = 0; tx8 = 0; dm8 = 0; ph8 = 1;
        end else begin
            if (ph8 == 2 && tx8 == 8 && q8.size() == 0) begin
                ph8 = 3;
                dm8 = 1;
            end
            if (rise && ph8 == 0) ph8 = 1;
            else if (fall && ph8 == 1) ph8 = 2;
            if (give) begin
                void'(q8.pop_front());
                tx8++;
            end
            if (take) begin
                q8.push_back(id8);
                rx8++;
                id8 = id8 + 16'd1;
            end
        end
        fq8 = f8;
    endtask

    task automatic arm8();
        f8 = 1'b1;
        cyc8();
        f8 = 1'b0;
        cyc8();
    endtask

    typedef struct {
        logic fl, iv;
        logic [15:0] d;
        logic ordy, e_ir, e_ov;
        logic [15:0] e_od, e_tx;
        logic e_done;
    } vec_t;
    vec_t tbl[11];

    logic [15:0] q2[$];
    int rx2, tx2;
    bit run2, dm2;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 16'h00aa, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 16'h00ab, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 16'h00ac, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 16'h0011, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 16'h0022, 1'b0, 1'b1, 1'b1, 16'h0011, 16'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0011, 16'd0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0022, 16'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 16'h0033, 1'b1, 1'b1, 1'b1, 16'h0022, 16'd1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0033, 16'd2, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'd3, 1'b0};

        rst = 1'b1;
        f8 = 0; iv8 = 0; or8 = 0; id8 = '0;
        f2 = 0; iv2 = 0; or2 = 0; id2 = '0;
        @(negedge clk);
        check("rst_in_ready", ir8, 1'b0);
        check("rst_out_valid", ov8, 1'b0);
        check("rst_out_data", od8, 16'h0);
        check("rst_tx_count", txd8, 16'd0);
        check("rst_done", dn8, 1'b0);
        do_reset();

        // flush rise/fall, words offered while armed are refused, then simple push/pop traffic
        for (int i = 0; i < 11; i++) begin
            f8 = tbl[i].fl; iv8 = tbl[i].iv; id8 = tbl[i].d; or8 = tbl[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), ir8, tbl[i].e_ir);
            check($sformatf("vec%0d_out_valid", i), ov8, tbl[i].e_ov);
            check($sformatf("vec%0d_out_data", i), od8, tbl[i].e_od);
            check($sformatf("vec%0d_tx_count", i), txd8, tbl[i].e_tx);
            check($sformatf("vec%0d_done", i), dn8, tbl[i].e_done);
            @(posedge clk);
            #1;
        end

        // full 8-word transfer with both sides always willing
        do_reset();
        arm8();
        iv8 = 1; id8 = 16'd1; or8 = 1;
        for (int c = 0; c < 40 && tx8 < 8; c++) cyc8();
        check("full_xfer_tx", txd8, 16'd8);
        cyc8();
        check("full_xfer_done", dn8, 1'b1);
        check("full_xfer_in_ready", ir8, 1'b0);
        repeat (3) cyc8();

        // back-pressure: exactly four words fit, then streaming resumes without loss
        do_reset();
        arm8();
        iv8 = 1; id8 = 16'h0101; or8 = 0; pushes8 = 0;
        repeat (6) cyc8();
        check("bp_pushes", pushes8, 4);
        check("bp_in_ready_full", ir8, 1'b0);
        or8 = 1;
        for (int c = 0; c < 40 && tx8 < 8; c++) cyc8();
        check("bp_tx", txd8, 16'd8);
        cyc8();
        check("bp_done", dn8, 1'b1);

        // restart after three deliveries, then a clean full transfer
        do_reset();
        arm8();
        iv8 = 1; id8 = 16'd1; or8 = 1;
        for (int c = 0; c < 20 && tx8 < 3; c++) cyc8();
        f8 = 1;
        cyc8();
        f8 = 0;
        cyc8();
        check("restart_tx", txd8, 16'd0);
        check("restart_done", dn8, 1'b0);
        check("restart_out_valid", ov8, 1'b0);
        for (int c = 0; c < 40 && tx8 < 8; c++) cyc8();
        check("restart_xfer_tx", txd8, 16'd8);
        cyc8();
        check("restart_xfer_done", dn8, 1'b1);

        // asynchronous reset with two words buffered, then no acceptance until re-armed
        do_reset();
        arm8();
        iv8 = 1; id8 = 16'd1; or8 = 0;
        cyc8();
        cyc8();
        check("pre_rst_out_valid", ov8, 1'b1);
        iv8 = 0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_out_valid", ov8, 1'b0);
        check("async_rst_in_ready", ir8, 1'b0);
        check("async_rst_done", dn8, 1'b0);
        check("async_rst_tx", txd8, 16'd0);
        check("async_rst_out_data", od8, 16'h0);
        do_reset();
        iv8 = 1; id8 = 16'h0050; or8 = 1;
        repeat (3) cyc8();

        // randomized traffic on the TX_SIZE=200 instance against an ordered queue model
        q2.delete();
        rx2 = 0; tx2 = 0; dm2 = 0;
        f2 = 1;
        @(posedge clk);
        #1 f2 = 0;
        @(posedge clk);
        #1 run2 = 1;
        for (int c = 0; c < 1000; c++) begin
            bit exp_ir, take, give;
            iv2 = 1'($urandom_range(0, 1));
            or2 = 1'($urandom_range(0, 1));
            id2 = 16'($urandom);
            @(negedge clk);
            exp_ir = run2 && q2.size() < 4 && rx2 < 200;
            check("rand_in_ready", ir2, exp_ir);
            check("rand_out_valid", ov2, q2.size() != 0);
            check("rand_out_data", od2, q2.size() != 0 ? q2[0] : 16'h0);
            check("rand_done", dn2, dm2);
            take = iv2 && exp_ir;
            give = q2.size() != 0 && or2;
            @(posedge clk);
            #1;
            if (run2 && tx2 == 200 && q2.size() == 0) begin
                run2 = 0;
                dm2 = 1;
            end
            if (give) begin
                void'(q2.pop_front());
                tx2++;
            end
            if (take) begin
                q2.push_back(id2);
                rx2++;
            end
        end
        check("rand_tx_count", txd2, tx2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
